// File: rtl/alu_pkg.sv
// Shared definitions for the operand-sequencing ALU front end:
// opcode and shift-code constants and the sequencer state encoding.
package alu_pkg;

    // ALU opcodes presented on alu_op
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // Operand B shift codes
    localparam logic [1:0] SH_NONE = 2'b00;  // pass through
    localparam logic [1:0] SH_LSL  = 2'b01;  // left by 1, LSB filled with 0
    localparam logic [1:0] SH_LSR  = 2'b10;  // logical right by 1
    localparam logic [1:0] SH_ASR  = 2'b11;  // arithmetic right by 1

    // Instruction sequencer states; one state per clock after IDLE
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_t;

endpackage

// File: rtl/reg_file.sv
// 8x16 register file: one synchronous write port, one combinational read
// port, all entries cleared by the asynchronous active-low reset.
module reg_file #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8,
    parameter int IDX_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [REG_CNT];

    // Storage: clear everything on reset, otherwise single write per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/alu_operand_seq.sv
// Operand sequencer for an external ALU. An instruction accepted in IDLE walks
// RD_A -> RD_B -> EXEC -> WB, fetching A and B from the register file,
// capturing the ALU result/flags and optionally writing the result back.
// External register writes are accepted only in IDLE and take effect before a
// simultaneously accepted instruction reads its operands.
// Handshake: start is sampled only in IDLE (busy=0); it is dropped, not
// queued, while busy=1. done pulses for exactly the WB cycle.
// Build option: define STATUS_CMP_ONLY_EN to update status only on SUB.
module alu_operand_seq
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [2:0]        rn,
    input  logic [2:0]        rm,
    input  logic [2:0]        rd,
    input  logic [1:0]        shift,
    input  logic [1:0]        op,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] sximm5,
    input  logic              wb_en,
    input  logic              wr_ext_en,
    input  logic [2:0]        wr_ext_num,
    input  logic [DATA_W-1:0] wr_ext_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_n,
    input  logic              alu_v,
    input  logic              alu_z,
    output logic [DATA_W-1:0] c_out,
    output logic [2:0]        status,
    output logic [2:0]        fsm_state
);

    state_t state, state_nxt;

    // Instruction fields captured when an instruction is accepted
    logic [2:0]        rn_q, rm_q, rd_q;
    logic [1:0]        shift_q, op_q;
    logic              asel_q, bsel_q, wb_en_q;
    logic [DATA_W-1:0] imm_q;

    logic [DATA_W-1:0] a_reg, b_reg, c_reg;
    logic [2:0]        status_q;

    logic              accept;
    logic              rf_we;
    logic [2:0]        rf_waddr, rf_raddr;
    logic [DATA_W-1:0] rf_wdata, rf_rdata, b_shifted;
    logic              status_upd;

    assign accept = (state == ST_IDLE) && start;

    // Write port is shared: external writes in IDLE, write-back in WB
    assign rf_we    = ((state == ST_IDLE) && wr_ext_en) || ((state == ST_WB) && wb_en_q);
    assign rf_waddr = (state == ST_WB) ? rd_q  : wr_ext_num;
    assign rf_wdata = (state == ST_WB) ? c_reg : wr_ext_data;
    // Read port is shared: rn during RD_A, rm during RD_B
    assign rf_raddr = (state == ST_RD_B) ? rm_q : rn_q;

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .IDX_W   (3)
    ) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: fixed walk once started
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RD_A;
            ST_RD_A: state_nxt = ST_RD_B;
            ST_RD_B: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_WB);
    end

    // Capture instruction fields on acceptance only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
            shift_q <= SH_NONE;
            op_q    <= OP_ADD;
            asel_q  <= 1'b0;
            bsel_q  <= 1'b0;
            wb_en_q <= 1'b0;
            imm_q   <= '0;
        end else if (accept) begin
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
            shift_q <= shift;
            op_q    <= op;
            asel_q  <= asel;
            bsel_q  <= bsel;
            wb_en_q <= wb_en;
            imm_q   <= sximm5;
        end
    end

    // Operand B shifter applied to the register read
    always_comb begin
        b_shifted = rf_rdata;
        case (shift_q)
            SH_LSL:  b_shifted = {rf_rdata[DATA_W-2:0], 1'b0};
            SH_LSR:  b_shifted = {1'b0, rf_rdata[DATA_W-1:1]};
            SH_ASR:  b_shifted = {rf_rdata[DATA_W-1], rf_rdata[DATA_W-1:1]};
            default: b_shifted = rf_rdata;
        endcase
    end

`ifdef STATUS_CMP_ONLY_EN
    assign status_upd = (op_q == OP_SUB);
`else
    assign status_upd = 1'b1;
`endif

    // Operand and result pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= '0;
            status_q <= '0;
        end else begin
            if (state == ST_RD_A) a_reg <= asel_q ? '0 : rf_rdata;
            if (state == ST_RD_B) b_reg <= bsel_q ? imm_q : b_shifted;
            if (state == ST_EXEC) begin
                c_reg <= alu_out;
                if (status_upd) status_q <= {alu_n, alu_v, alu_z};
            end
        end
    end

    assign alu_a     = a_reg;
    assign alu_b     = b_reg;
    assign alu_op    = op_q;
    assign c_out     = c_reg;
    assign status    = status_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Bench for alu_operand_seq: provides the downstream ALU, keeps a shadow
// register file, and checks each completed instruction against a queue of
// expected {status, c_out} values.
module tb_alu_operand_seq;
    import alu_pkg::*;

    localparam int DATA_W = 16;
    localparam int SB_W   = DATA_W + 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done;
    logic [2:0]        rn = '0, rm = '0, rd = '0;
    logic [1:0]        shift = '0, op = '0;
    logic              asel = 1'b0, bsel = 1'b0, wb_en = 1'b0;
    logic [DATA_W-1:0] sximm5 = '0;
    logic              wr_ext_en = 1'b0;
    logic [2:0]        wr_ext_num = '0;
    logic [DATA_W-1:0] wr_ext_data = '0;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [1:0]        alu_op;
    logic              alu_n, alu_v, alu_z;
    logic [DATA_W-1:0] c_out;
    logic [2:0]        status, fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [SB_W-1:0]   exp_q[$];
    logic [DATA_W-1:0] m_regs [8];
    logic [2:0]        m_status = '0;

    alu_operand_seq #(.DATA_W(16), .REG_CNT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rn(rn), .rm(rm), .rd(rd), .shift(shift), .op(op), .asel(asel), .bsel(bsel),
        .sximm5(sximm5), .wb_en(wb_en), .wr_ext_en(wr_ext_en), .wr_ext_num(wr_ext_num),
        .wr_ext_data(wr_ext_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
        .c_out(c_out), .status(status), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- downstream ALU model ----------------
    // returns {n, v, z, result}
    function automatic logic [SB_W-1:0] alu_calc(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [1:0] o);
        logic [DATA_W-1:0] r;
        logic v;
        r = '0;
        v = 1'b0;
        case (o)
            OP_ADD: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            OP_SUB: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            OP_AND: r = a & b;
            default: r = ~b;
        endcase
        return {r[15], v, (r == '0), r};
    endfunction

    logic [SB_W-1:0] alu_res;
    always_comb begin
        alu_res = alu_calc(alu_a, alu_b, alu_op);
        alu_out = alu_res[DATA_W-1:0];
        alu_n   = alu_res[DATA_W+2];
        alu_v   = alu_res[DATA_W+1];
        alu_z   = alu_res[DATA_W];
    end

    // ---------------- driver tasks ----------------
    task automatic ext_write(input logic [2:0] num, input logic [DATA_W-1:0] data);
        @(negedge clk);
        wr_ext_en = 1'b1; wr_ext_num = num; wr_ext_data = data;
        m_regs[num] = data;
        @(posedge clk); #1;
        wr_ext_en = 1'b0;
    endtask

    // Drive one start cycle (optionally with a same-cycle external write)
    // and push the modelled result when push=1.
    task automatic issue(input logic [2:0] i_rn, input logic [2:0] i_rm, input logic [2:0] i_rd,
                         input logic [1:0] i_shift, input logic [1:0] i_op,
                         input logic i_asel, input logic i_bsel, input logic [DATA_W-1:0] i_imm,
                         input logic i_wb, input logic x_en, input logic [2:0] x_num,
                         input logic [DATA_W-1:0] x_data, input logic push);
        logic [DATA_W-1:0] a, b, rv;
        logic [SB_W-1:0]   res;
        logic [2:0]        st;
        @(negedge clk);
        rn = i_rn; rm = i_rm; rd = i_rd; shift = i_shift; op = i_op;
        asel = i_asel; bsel = i_bsel; sximm5 = i_imm; wb_en = i_wb;
        wr_ext_en = x_en; wr_ext_num = x_num; wr_ext_data = x_data;
        start = 1'b1;
        if (x_en) m_regs[x_num] = x_data;
        a  = i_asel ? '0 : m_regs[i_rn];
        rv = m_regs[i_rm];
        case (i_shift)
            SH_LSL:  b = {rv[14:0], 1'b0};
            SH_LSR:  b = {1'b0, rv[15:1]};
            SH_ASR:  b = {rv[15], rv[15:1]};
            default: b = rv;
        endcase
        if (i_bsel) b = i_imm;
        res = alu_calc(a, b, i_op);
        st  = res[SB_W-1:DATA_W];
`ifdef STATUS_CMP_ONLY_EN
        if (i_op != OP_SUB) st = m_status;
`endif
        m_status = st;
        if (i_wb) m_regs[i_rd] = res[DATA_W-1:0];
        if (push) exp_q.push_back({st, res[DATA_W-1:0]});
        @(posedge clk); #1;
        start = 1'b0;
        wr_ext_en = 1'b0;
    endtask

    // Shorthand: read R[r] out through c_out (A forced to 0, B=R[r], ADD, no write-back)
    task automatic issue_read(input logic [2:0] r);
        issue(3'd0, r, 3'd0, SH_NONE, OP_ADD, 1'b1, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
    endtask

    // Scoreboard: wait (bounded) for done, pop and compare {status, c_out}
    task automatic collect(output int lat);
        logic got;
        logic [SB_W-1:0] e;
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12 && !got; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; lat = n; end
        end
        n_checks++;
        if (!got) begin
            $display("FAIL collect_done: done not seen within 12 cycles");
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            $display("FAIL collect_queue: done seen with empty expected queue");
        end else begin
            e = exp_q.pop_front();
            if ({status, c_out} !== e)
                $display("FAIL collect_result: got status=%b c_out=%h expected status=%b c_out=%h",
                         status, c_out, e[SB_W-1:DATA_W], e[DATA_W-1:0]);
            else n_pass++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, fsm_state} !== {1'b0, 1'b0, 3'(ST_IDLE)})
            $display("FAIL reset_ctrl: busy=%b done=%b state=%0d expected 0 0 0", busy, done, fsm_state);
        else n_pass++;
        n_checks++;
        if ({c_out, status, alu_a, alu_b} !== '0)
            $display("FAIL reset_data: c_out=%h status=%b a=%h b=%h expected all 0", c_out, status, alu_a, alu_b);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_add();
        int lat;
        ext_write(3'd1, 16'd5);
        ext_write(3'd2, 16'd3);
        issue(3'd1, 3'd2, 3'd3, SH_NONE, OP_ADD, 1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        collect(lat);
        n_checks++;
        if (lat !== 4) $display("FAIL add_latency: done after %0d cycles expected 4", lat);
        else n_pass++;
        n_checks++;
        if ({status, c_out} !== {3'b000, 16'd8})
            $display("FAIL add_value: status=%b c_out=%h expected 000 0008", status, c_out);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL add_busy_drop: busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
        issue_read(3'd3);   // R3 must now hold 8
        collect(lat);
        n_checks++;
        if (c_out !== 16'd8) $display("FAIL add_writeback: R3=%h expected 0008", c_out);
        else n_pass++;
    endtask

    task automatic test_sub();
        int lat;
        ext_write(3'd1, 16'd5);
        ext_write(3'd2, 16'd5);
        issue(3'd1, 3'd2, 3'd4, SH_NONE, OP_SUB, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
        collect(lat);
        n_checks++;
        if ({status, c_out} !== {3'b001, 16'h0000})
            $display("FAIL sub_zero: status=%b c_out=%h expected 001 0000", status, c_out);
        else n_pass++;
        ext_write(3'd1, 16'h7FFF);
        ext_write(3'd2, 16'hFFFF);
        issue(3'd1, 3'd2, 3'd4, SH_NONE, OP_SUB, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
        collect(lat);
        n_checks++;
        if (status !== 3'b110) $display("FAIL sub_overflow: status=%b expected 110", status);
        else n_pass++;
    endtask

    task automatic test_shift();
        int lat;
        logic [1:0]        codes [3];
        logic [DATA_W-1:0] want  [3];
        codes[0] = SH_ASR; want[0] = 16'hC001;
        codes[1] = SH_LSR; want[1] = 16'h4001;
        codes[2] = SH_LSL; want[2] = 16'h0004;
        ext_write(3'd2, 16'h8002);
        for (int i = 0; i < 3; i++) begin
            issue(3'd0, 3'd2, 3'd0, codes[i], OP_ADD, 1'b1, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
            collect(lat);
            n_checks++;
            if (alu_b !== want[i]) $display("FAIL shift_b%0d: alu_b=%h expected %h", i, alu_b, want[i]);
            else n_pass++;
        end
        // immediate operand and same-cycle external write + start
        issue(3'd6, 3'd0, 3'd0, SH_NONE, OP_ADD, 1'b0, 1'b1, 16'h0021, 1'b0, 1'b1, 3'd6, 16'd9, 1'b1);
        collect(lat);
        n_checks++;
        if (c_out !== 16'h002A) $display("FAIL ext_then_read: c_out=%h expected 002a", c_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, t0, ndone;
        logic [SB_W-1:0] e;
        logic [SB_W-1:0] seen;
        // start during RD_B with different fields must be ignored
        ext_write(3'd1, 16'd10);
        ext_write(3'd2, 16'd4);
        issue(3'd1, 3'd2, 3'd0, SH_NONE, OP_SUB, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
        @(negedge clk);         // RD_A
        @(negedge clk);         // RD_B
        rn = 3'd2; rm = 3'd1; op = OP_ADD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        seen = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) seen = {status, c_out};
            end
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++;
        if (ndone !== 1) $display("FAIL start_ignored: saw %0d done pulses expected 1", ndone);
        else n_pass++;
        n_checks++;
        if (seen !== e) $display("FAIL start_ignored_result: got %h expected %h", seen, e);
        else n_pass++;
        // ext write while busy must be dropped
        ext_write(3'd4, 16'h1234);
        issue(3'd0, 3'd0, 3'd0, SH_NONE, OP_AND, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
        @(negedge clk);
        wr_ext_en = 1'b1; wr_ext_num = 3'd4; wr_ext_data = 16'hAAAA;
        @(posedge clk); #1;
        wr_ext_en = 1'b0;
        collect(lat);
        issue_read(3'd4);
        collect(lat);
        n_checks++;
        if (c_out !== 16'h1234) $display("FAIL ext_while_busy: R4=%h expected 1234", c_out);
        else n_pass++;
        // back-to-back issue in the IDLE cycle: 5-cycle spacing of done
        issue(3'd1, 3'd2, 3'd5, SH_NONE, OP_ADD, 1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        collect(lat);
        t0 = cyc;
        issue(3'd5, 3'd2, 3'd6, SH_NONE, OP_SUB, 1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        collect(lat);
        n_checks++;
        if (cyc - t0 !== 5) $display("FAIL back_to_back: done spacing %0d cycles expected 5", cyc - t0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, ndone;
        ext_write(3'd1, 16'd5);
        ext_write(3'd2, 16'd3);
        issue(3'd1, 3'd2, 3'd7, SH_NONE, OP_ADD, 1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
        @(negedge clk);         // RD_A
        @(negedge clk);         // RD_B
        @(negedge clk);         // EXEC
        n_checks++;
        if (fsm_state !== 3'(ST_EXEC)) $display("FAIL abort_in_exec: state=%0d expected %0d", fsm_state, ST_EXEC);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({fsm_state, busy, done, status, c_out} !== {3'(ST_IDLE), 1'b0, 1'b0, 3'b000, 16'h0000})
            $display("FAIL abort_async: state=%0d busy=%b done=%b status=%b c_out=%h expected all 0",
                     fsm_state, busy, done, status, c_out);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_status = '0;
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone !== 0) $display("FAIL abort_no_done: saw %0d done pulses expected 0", ndone);
        else n_pass++;
        issue_read(3'd7);
        collect(lat);
        n_checks++;
        if (c_out !== 16'h0000) $display("FAIL abort_no_wb: R7=%h expected 0000", c_out);
        else n_pass++;
    endtask

    task automatic test_status_hold();
        int lat;
        logic [2:0] want;
        ext_write(3'd1, 16'd5);
        ext_write(3'd2, 16'd5);
        issue(3'd1, 3'd2, 3'd0, SH_NONE, OP_SUB, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
        collect(lat);
        issue(3'd1, 3'd2, 3'd0, SH_NONE, OP_ADD, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
        collect(lat);
`ifdef STATUS_CMP_ONLY_EN
        want = 3'b001;
`else
        want = 3'b000;
`endif
        n_checks++;
        if ({status, c_out} !== {want, 16'd10})
            $display("FAIL status_after_add: status=%b c_out=%h expected %b 000a", status, c_out, want);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        for (int k = 0; k < 20; k++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  16'($urandom_range(0, 65535)), 1'b1);
            collect(lat);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_back_to_back();
        test_reset_mid();
        test_status_hold();
        test_random();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL queue_drain: %0d expected results left", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
